warp_pc_table: RTL and testbench
================================

Name: warp_pc_table

Overview:
- Multi-warp program-counter store that replaces the single-warp PC register in the fetch stage.
- Holds one PC and one activity state per warp and serves the fetch-address read for the warp granted by the fetch arbiter.
- Applies per-warp start, exit, branch redirect (ALU / SIMT / decode), replay rollback and sequential advance.
- Raises a registered flush pulse so IF/ID can drop in-flight instructions of a redirected warp.

Parameters:
NUM_WARPS, 8, number of warps tracked; WID_W = max(1, clog2(NUM_WARPS))
PC_W, 32, PC width in bits
INSTR_BYTES, 4, bytes per instruction; power of two; ALIGN = log2(INSTR_BYTES)
FETCH_WIDTH, 2, instructions fetched per grant; 1..4
CNT_W, 3, width of the rollback count

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start_valid  in  1  task manager launches a warp
start_wid  in  WID_W  warp being launched
start_pc  in  PC_W  starting PC
exit_valid  in  1  warp has executed EXIT
exit_wid  in  WID_W  exiting warp
fetch_grant  in  1  round-robin arbiter grants one fetch this cycle
fetch_wid  in  WID_W  granted warp (also the read address)
fetch_pc  out  PC_W  combinational PC of fetch_wid
alu_br_valid  in  1  ALU resolved branch taken
alu_br_wid  in  WID_W  warp of the ALU branch
alu_br_target  in  PC_W  ALU branch target
simt_br_valid  in  1  SIMT stack reconvergence or divergence target
simt_br_wid  in  WID_W  warp of the SIMT redirect
simt_br_target  in  PC_W  SIMT target
id_jmp_valid  in  1  decode-resolved unconditional jump
id_jmp_wid  in  WID_W  warp of the jump
id_jmp_target  in  PC_W  jump target
replay_valid  in  1  instructions must be refetched (SIMT/IBuffer stall)
replay_wid  in  WID_W  warp to roll back
replay_cnt  in  CNT_W  number of instructions to roll back; 0 = no-op
active_mask  out  NUM_WARPS  registered; bit w = warp w ACTIVE
flush_valid  out  1  registered pulse; a redirect was applied last cycle
flush_wid  out  WID_W  warp to flush
err_idle_fetch  out  1  registered pulse; grant was issued to a non-ACTIVE warp

Behaviour:
- Reset (rst_n=0 at clk edge): all PCs 0; all warps IDLE; active_mask=0; flush_valid=0; flush_wid=0; err_idle_fetch=0. Reset overrides every other input.
- Per-warp FSM, two states:
  - IDLE -> ACTIVE on start_valid for that warp.
  - ACTIVE -> IDLE on exit_valid for that warp.
  - start_valid on an already ACTIVE warp reloads its PC and keeps it ACTIVE.
- Per-warp PC update priority, highest first, evaluated independently for each warp w in the same cycle:
  1. start
  2. exit (PC held)
  3. ALU redirect
  4. SIMT redirect
  5. ID jump
  6. replay
  7. fetch advance
  Only the highest-priority matching event for w takes effect; all lower-priority events for w are discarded that cycle. Events addressing different warps all apply in the same cycle.
- Redirects (ALU, SIMT, ID) and replay apply only to ACTIVE warps; they are ignored for IDLE warps.
- Redirect: PC <= target with the low ALIGN bits forced to 0.
  - Next cycle: flush_valid=1 and flush_wid=w.
  - If several warps are redirected in one cycle, flush reports the lowest warp id; the others are also updated but not flushed. Upstream guarantees at most one redirect per cycle.
- Replay: PC <= PC - replay_cnt*INSTR_BYTES, modulo 2^PC_W; no flush.
- Fetch advance: when fetch_grant is asserted and fetch_wid is ACTIVE, PC <= PC + FETCH_WIDTH*INSTR_BYTES, modulo 2^PC_W (0xFFFFFFF8 + 8 -> 0x0). If fetch_wid is IDLE, no update and err_idle_fetch=1 next cycle.
- fetch_pc = PC[fetch_wid] from the current register value, with zero latency. It does not reflect same-cycle updates.
- Out-of-range wid (>= NUM_WARPS when NUM_WARPS is not a power of two): the event is ignored; fetch_pc reads 0.
- All state updates occur on the posedge. The new PC is visible on fetch_pc the cycle after the update.

Test Plan:
- Reset, then start_valid wid=3 pc=0x100 -> next cycle active_mask=0x08, fetch_pc(wid 3)=0x100; three fetch grants -> 0x108, 0x110, 0x118.
- Warp 3 at 0x118: same cycle alu_br target 0x400, id_jmp target 0x800, fetch_grant -> PC=0x400; flush_valid=1, flush_wid=3 one cycle later, then flush_valid=0.
- Warp 3 at 0x400, replay_cnt=3 with fetch_grant in the same cycle -> PC=0x3F4; replay_cnt=0 -> PC unchanged.
- Same cycle: fetch_grant wid=1 (ACTIVE, 0x20), simt_br wid=5 target 0x203 (ACTIVE) -> warp1=0x28, warp5=0x200; flush_wid=5.
- Warp at 0xFFFFFFF8 granted -> PC=0x00000000; exit_valid on it -> active_mask bit cleared; a later grant to it -> PC unchanged, err_idle_fetch pulses for one cycle.
- rst_n=0 mid-stream with redirect and grant asserted -> next cycle all PCs 0, active_mask=0, flush_valid=0.

Source files
------------

// File: rtl/warp_pc_table.sv
// Per-warp PC/activity store for fetch; fetch_pc is combinational, updates land on the next posedge.
// No backpressure: every event is consumed in the cycle it is presented; flush/err are 1-cycle pulses.
module warp_pc_table #(
  parameter int NUM_WARPS   = 8,
  parameter int PC_W        = 32,
  parameter int INSTR_BYTES = 4,
  parameter int FETCH_WIDTH = 2,
  parameter int CNT_W       = 3,
  localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  input  logic [WID_W-1:0]     start_wid,
  input  logic [PC_W-1:0]      start_pc,
  input  logic                 exit_valid,
  input  logic [WID_W-1:0]     exit_wid,
  input  logic                 fetch_grant,
  input  logic [WID_W-1:0]     fetch_wid,
  output logic [PC_W-1:0]      fetch_pc,
  input  logic                 alu_br_valid,
  input  logic [WID_W-1:0]     alu_br_wid,
  input  logic [PC_W-1:0]      alu_br_target,
  input  logic                 simt_br_valid,
  input  logic [WID_W-1:0]     simt_br_wid,
  input  logic [PC_W-1:0]      simt_br_target,
  input  logic                 id_jmp_valid,
  input  logic [WID_W-1:0]     id_jmp_wid,
  input  logic [PC_W-1:0]      id_jmp_target,
  input  logic                 replay_valid,
  input  logic [WID_W-1:0]     replay_wid,
  input  logic [CNT_W-1:0]     replay_cnt,
  output logic [NUM_WARPS-1:0] active_mask,
  output logic                 flush_valid,
  output logic [WID_W-1:0]     flush_wid,
  output logic                 err_idle_fetch
);

  localparam int ALIGN = $clog2(INSTR_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(INSTR_BYTES - 1);
  localparam logic [PC_W-1:0] FETCH_STEP = PC_W'(FETCH_WIDTH * INSTR_BYTES);

  logic [PC_W-1:0]      pcReg  [NUM_WARPS];
  logic [PC_W-1:0]      pcNext [NUM_WARPS];
  logic [NUM_WARPS-1:0] activeReg;
  logic [NUM_WARPS-1:0] activeNext;
  logic [NUM_WARPS-1:0] redirHit;
  logic [WID_W-1:0]     flushWidNext;
  logic                 fetchInRange;
  logic                 errNext;
  logic [PC_W-1:0]      replayDelta;

  assign fetchInRange = int'(fetch_wid) < NUM_WARPS;
  assign replayDelta  = PC_W'(replay_cnt) << ALIGN;

  always_comb begin
    fetch_pc = '0;
    if (fetchInRange) fetch_pc = pcReg[fetch_wid];
  end

  // Each warp independently takes only its highest-priority event this cycle.
  always_comb begin
    activeNext = activeReg;
    redirHit   = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pcNext[w] = pcReg[w];
      if (start_valid && start_wid == WID_W'(w)) begin
        pcNext[w]     = start_pc;
        activeNext[w] = 1'b1;
      end else if (exit_valid && exit_wid == WID_W'(w)) begin
        activeNext[w] = 1'b0;
      end else if (activeReg[w] && alu_br_valid && alu_br_wid == WID_W'(w)) begin
        pcNext[w]   = alu_br_target & ALIGN_MASK;
        redirHit[w] = 1'b1;
      end else if (activeReg[w] && simt_br_valid && simt_br_wid == WID_W'(w)) begin
        pcNext[w]   = simt_br_target & ALIGN_MASK;
        redirHit[w] = 1'b1;
      end else if (activeReg[w] && id_jmp_valid && id_jmp_wid == WID_W'(w)) begin
        pcNext[w]   = id_jmp_target & ALIGN_MASK;
        redirHit[w] = 1'b1;
      end else if (activeReg[w] && replay_valid && replay_cnt != '0
                   && replay_wid == WID_W'(w)) begin
        pcNext[w] = pcReg[w] - replayDelta;
      end else if (activeReg[w] && fetch_grant && fetch_wid == WID_W'(w)) begin
        pcNext[w] = pcReg[w] + FETCH_STEP;
      end
    end
  end

  // Lowest redirected warp id wins the flush report.
  always_comb begin
    flushWidNext = '0;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (redirHit[w]) flushWidNext = WID_W'(w);
    end
  end

  assign errNext = fetch_grant && fetchInRange && !activeReg[fetch_wid];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) pcReg[w] <= '0;
      activeReg      <= '0;
      flush_valid    <= 1'b0;
      flush_wid      <= '0;
      err_idle_fetch <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) pcReg[w] <= pcNext[w];
      activeReg      <= activeNext;
      flush_valid    <= |redirHit;
      flush_wid      <= flushWidNext;
      err_idle_fetch <= errNext;
    end
  end

  assign active_mask = activeReg;

endmodule

// File: tb/tb_warp_pc_table.sv
// Randomized and directed bench for warp_pc_table against a per-warp behavioural model.
module tb_warp_pc_table;
  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, exit_valid, fetch_grant;
  logic        alu_br_valid, simt_br_valid, id_jmp_valid, replay_valid;
  logic [2:0]  start_wid, exit_wid, fetch_wid, alu_br_wid, simt_br_wid, id_jmp_wid, replay_wid;
  logic [31:0] start_pc, alu_br_target, simt_br_target, id_jmp_target;
  logic [2:0]  replay_cnt;
  logic [31:0] fetch_pc;
  logic [7:0]  active_mask;
  logic        flush_valid, err_idle_fetch;
  logic [2:0]  flush_wid;

  int errors = 0;
  int checks = 0;

  logic [31:0] mPc [NW];
  logic [7:0]  mAct;
  logic        mFv, mErr;
  logic [2:0]  mFw;

  always #5 clk = ~clk;

  warp_pc_table dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_wid(start_wid), .start_pc(start_pc),
    .exit_valid(exit_valid), .exit_wid(exit_wid),
    .fetch_grant(fetch_grant), .fetch_wid(fetch_wid), .fetch_pc(fetch_pc),
    .alu_br_valid(alu_br_valid), .alu_br_wid(alu_br_wid), .alu_br_target(alu_br_target),
    .simt_br_valid(simt_br_valid), .simt_br_wid(simt_br_wid), .simt_br_target(simt_br_target),
    .id_jmp_valid(id_jmp_valid), .id_jmp_wid(id_jmp_wid), .id_jmp_target(id_jmp_target),
    .replay_valid(replay_valid), .replay_wid(replay_wid), .replay_cnt(replay_cnt),
    .active_mask(active_mask), .flush_valid(flush_valid), .flush_wid(flush_wid),
    .err_idle_fetch(err_idle_fetch)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic quiet();
    start_valid = 0; exit_valid = 0; fetch_grant = 0; alu_br_valid = 0;
    simt_br_valid = 0; id_jmp_valid = 0; replay_valid = 0; replay_cnt = 0;
  endtask

  // One clock: check the combinational read, advance the model, check registered outputs.
  task automatic tick();
    logic [31:0] nPc [NW];
    logic [7:0]  nAct;
    logic        fv, er;
    logic [2:0]  fw;
    @(negedge clk);
    checkVal("fetch_pc", fetch_pc, mPc[fetch_wid]);
    fv = 0; fw = 0; nAct = mAct;
    er = fetch_grant && !mAct[fetch_wid];
    for (int w = NW - 1; w >= 0; w--) begin
      bit redir = 0;
      nPc[w] = mPc[w];
      if (start_valid && start_wid == w) begin
        nPc[w] = start_pc; nAct[w] = 1;
      end else if (exit_valid && exit_wid == w) begin
        nAct[w] = 0;
      end else if (!mAct[w]) begin
        // idle warps ignore redirects, replay and fetch
      end else if (alu_br_valid && alu_br_wid == w) begin
        nPc[w] = {alu_br_target[31:2], 2'b00}; redir = 1;
      end else if (simt_br_valid && simt_br_wid == w) begin
        nPc[w] = {simt_br_target[31:2], 2'b00}; redir = 1;
      end else if (id_jmp_valid && id_jmp_wid == w) begin
        nPc[w] = {id_jmp_target[31:2], 2'b00}; redir = 1;
      end else if (replay_valid && replay_wid == w && replay_cnt != 0) begin
        nPc[w] = mPc[w] - 32'(replay_cnt) * 4;
      end else if (fetch_grant && fetch_wid == w) begin
        nPc[w] = mPc[w] + 8;
      end
      if (redir) begin fv = 1; fw = 3'(w); end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int w = 0; w < NW; w++) mPc[w] = 0;
      mAct = 0; mFv = 0; mFw = 0; mErr = 0;
    end else begin
      for (int w = 0; w < NW; w++) mPc[w] = nPc[w];
      mAct = nAct; mFv = fv; mFw = fw; mErr = er;
    end
    checkVal("active_mask", 32'(active_mask), 32'(mAct));
    checkVal("flush_valid", 32'(flush_valid), 32'(mFv));
    if (mFv) checkVal("flush_wid", 32'(flush_wid), 32'(mFw));
    checkVal("err_idle_fetch", 32'(err_idle_fetch), 32'(mErr));
  endtask

  initial begin
    for (int w = 0; w < NW; w++) mPc[w] = 0;
    mAct = 0; mFv = 0; mFw = 0; mErr = 0;
    quiet();
    start_wid = 0; exit_wid = 0; fetch_wid = 0; alu_br_wid = 0; simt_br_wid = 0;
    id_jmp_wid = 0; replay_wid = 0; start_pc = 0; alu_br_target = 0;
    simt_br_target = 0; id_jmp_target = 0;
    rst_n = 0;
    @(posedge clk); #1;
    tick(); tick();
    checkVal("rst_mask", 32'(active_mask), 0);
    checkVal("rst_flush_wid", 32'(flush_wid), 0);
    checkVal("rst_pc", fetch_pc, 0);
    rst_n = 1;

    // launch warp 3 and advance it three times
    start_valid = 1; start_wid = 3; start_pc = 32'h100; fetch_wid = 3;
    tick(); quiet();
    checkVal("start_mask", 32'(active_mask), 32'h08);
    checkVal("start_pc", fetch_pc, 32'h100);
    fetch_grant = 1;
    tick(); checkVal("adv1", fetch_pc, 32'h108);
    tick(); checkVal("adv2", fetch_pc, 32'h110);
    tick(); checkVal("adv3", fetch_pc, 32'h118);

    // ALU redirect beats decode jump and fetch
    alu_br_valid = 1; alu_br_wid = 3; alu_br_target = 32'h400;
    id_jmp_valid = 1; id_jmp_wid = 3; id_jmp_target = 32'h800;
    tick(); quiet();
    checkVal("alu_pc", fetch_pc, 32'h400);
    checkVal("alu_flush", 32'(flush_valid), 1);
    checkVal("alu_flush_wid", 32'(flush_wid), 3);
    tick(); checkVal("flush_drop", 32'(flush_valid), 0);

    // replay beats fetch; zero-count replay is a no-op
    replay_valid = 1; replay_wid = 3; replay_cnt = 3; fetch_grant = 1;
    tick(); quiet(); checkVal("replay3", fetch_pc, 32'h3F4);
    replay_valid = 1; replay_wid = 3; replay_cnt = 0;
    tick(); quiet(); checkVal("replay0", fetch_pc, 32'h3F4);

    // independent warps in one cycle, misaligned SIMT target
    start_valid = 1; start_wid = 1; start_pc = 32'h20; tick();
    start_wid = 5; start_pc = 32'h1000; tick(); quiet();
    fetch_grant = 1; fetch_wid = 1;
    simt_br_valid = 1; simt_br_wid = 5; simt_br_target = 32'h203;
    tick(); quiet();
    checkVal("w1_adv", fetch_pc, 32'h28);
    checkVal("simt_flush_wid", 32'(flush_wid), 5);
    fetch_wid = 5; #1 checkVal("w5_pc", fetch_pc, 32'h200);

    // wrap, exit, then grant to the idle warp
    start_valid = 1; start_wid = 6; start_pc = 32'hFFFF_FFF8; fetch_wid = 6;
    tick(); quiet();
    fetch_grant = 1; tick(); quiet(); checkVal("wrap", fetch_pc, 32'h0);
    exit_valid = 1; exit_wid = 6; tick(); quiet();
    checkVal("exit_mask", 32'(active_mask), 32'h2A);
    fetch_grant = 1; tick(); quiet();
    checkVal("idle_err", 32'(err_idle_fetch), 1);
    checkVal("idle_pc", fetch_pc, 32'h0);
    tick(); checkVal("idle_err_drop", 32'(err_idle_fetch), 0);

    // reset mid-stream wins over redirect and grant
    alu_br_valid = 1; alu_br_wid = 3; alu_br_target = 32'h900; fetch_grant = 1; fetch_wid = 3;
    rst_n = 0; tick(); quiet(); rst_n = 1;
    checkVal("mid_rst_mask", 32'(active_mask), 0);
    checkVal("mid_rst_flush", 32'(flush_valid), 0);
    checkVal("mid_rst_pc", fetch_pc, 0);

    for (int i = 0; i < 800; i++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      start_valid    = ($urandom_range(0, 2) == 0);
      start_wid      = 3'($urandom);
      start_pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      exit_valid     = ($urandom_range(0, 7) == 0);
      exit_wid       = 3'($urandom);
      fetch_grant    = ($urandom_range(0, 1) == 0);
      fetch_wid      = 3'($urandom);
      alu_br_valid   = ($urandom_range(0, 5) == 0);
      alu_br_wid     = 3'($urandom);
      alu_br_target  = $urandom;
      simt_br_valid  = ($urandom_range(0, 5) == 0);
      simt_br_wid    = 3'($urandom);
      simt_br_target = $urandom;
      id_jmp_valid   = ($urandom_range(0, 5) == 0);
      id_jmp_wid     = 3'($urandom);
      id_jmp_target  = $urandom;
      replay_valid   = ($urandom_range(0, 4) == 0);
      replay_wid     = 3'($urandom);
      replay_cnt     = 3'($urandom_range(1, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
